// File: rtl/multicycle_control.sv
// Control unit for a multicycle RV32I-subset datapath: one Moore FSM plus
// combinational decode of the ALU operation and immediate format.
module multicycle_control #(
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                i_op,
  input  logic [2:0]                i_funct3,
  input  logic                      i_funct7b5,
  input  logic                      i_zero,
  input  logic                      i_result_lsb,
  input  logic                      i_mem_ready,
  output logic                      o_pc_write,
  output logic                      o_ir_write,
  output logic                      o_reg_write,
  output logic                      o_mem_write,
  output logic                      o_adr_src,
  output logic [1:0]                o_result_src,
  output logic [1:0]                o_alu_src_a,
  output logic [1:0]                o_alu_src_b,
  output logic [2:0]                o_imm_src,
  output logic [ALU_CTRL_WIDTH-1:0] o_alu_control,
  output logic                      o_illegal_op
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = ALU_CTRL_WIDTH'(4'd0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = ALU_CTRL_WIDTH'(4'd1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = ALU_CTRL_WIDTH'(4'd2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = ALU_CTRL_WIDTH'(4'd3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = ALU_CTRL_WIDTH'(4'd4);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = ALU_CTRL_WIDTH'(4'd5);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = ALU_CTRL_WIDTH'(4'd6);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = ALU_CTRL_WIDTH'(4'd7);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = ALU_CTRL_WIDTH'(4'd8);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = ALU_CTRL_WIDTH'(4'd9);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_ILLEGAL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                      w_pc_write;
  logic                      w_ir_write;
  logic                      w_reg_write;
  logic                      w_mem_write;
  logic                      w_illegal_op;
  logic                      w_adr_src;
  logic [1:0]                w_result_src;
  logic [1:0]                w_alu_src_a;
  logic [1:0]                w_alu_src_b;
  logic [ALU_CTRL_WIDTH-1:0] w_alu_control;
  logic [ALU_CTRL_WIDTH-1:0] w_alu_op;
  logic [ALU_CTRL_WIDTH-1:0] w_branch_alu;
  logic                      w_branch_taken;
  logic                      w_branch_f3_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Arithmetic op for EXECR/EXECI; sub only exists in R-type, sra in both.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (i_funct3)
      3'b000:  w_alu_op = ((i_op == OP_RTYPE) && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  // Odd funct3 values invert the comparison outcome (bne, bge, bgeu).
  always_comb begin
    w_branch_alu   = ALU_SUB;
    w_branch_taken = 1'b0;
    case (i_funct3[2:1])
      2'b00: begin
        w_branch_alu   = ALU_SUB;
        w_branch_taken = i_zero ^ i_funct3[0];
      end
      2'b10: begin
        w_branch_alu   = ALU_SLT;
        w_branch_taken = i_result_lsb ^ i_funct3[0];
      end
      2'b11: begin
        w_branch_alu   = ALU_SLTU;
        w_branch_taken = i_result_lsb ^ i_funct3[0];
      end
      default: begin
        w_branch_alu   = ALU_SUB;
        w_branch_taken = 1'b0;
      end
    endcase
  end

  assign w_branch_f3_ok = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);

  always_comb begin
    case (i_op)
      OP_STORE:  o_imm_src = 3'b001;
      OP_BRANCH: o_imm_src = 3'b010;
      OP_JAL:    o_imm_src = 3'b011;
      OP_LUI:    o_imm_src = 3'b100;
      default:   o_imm_src = 3'b000;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_illegal_op  = 1'b0;
    w_adr_src     = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
        if (i_mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (i_op)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECR;
          OP_ITYPE:          w_state_next = S_EXECI;
          OP_BRANCH:         w_state_next = w_branch_f3_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            w_state_next = S_JAL;
          OP_LUI:            w_state_next = S_LUI;
          default:           w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_state_next = (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (i_mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (i_mem_ready) w_state_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = w_alu_op;
        w_state_next  = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_alu_control = w_alu_op;
        w_state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = w_branch_alu;
        w_pc_write    = w_branch_taken;
        w_state_next  = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_pc_write   = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_LUI: begin
        w_alu_src_a  = 2'b11;
        w_alu_src_b  = 2'b01;
        w_state_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        w_illegal_op = 1'b1;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Side effects are suppressed for the whole reset cycle, whatever the state.
  assign o_pc_write    = w_pc_write & ~rst;
  assign o_ir_write    = w_ir_write & ~rst;
  assign o_reg_write   = w_reg_write & ~rst;
  assign o_mem_write   = w_mem_write & ~rst;
  assign o_illegal_op  = w_illegal_op & ~rst;
  assign o_adr_src     = w_adr_src;
  assign o_result_src  = w_result_src;
  assign o_alu_src_a   = w_alu_src_a;
  assign o_alu_src_b   = w_alu_src_b;
  assign o_alu_control = w_alu_control;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: an instruction-level model expands each instruction into
// its expected per-cycle control vectors; a negedge monitor compares them.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       b5, zero, lsb, mr;
  logic       pcw, irw, rw, mw, adr, ill;
  logic [1:0] rs, sa, sb;
  logic [2:0] imm;
  logic [3:0] alu;

  multicycle_control #(.ALU_CTRL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(b5),
    .i_zero(zero), .i_result_lsb(lsb), .i_mem_ready(mr),
    .o_pc_write(pcw), .o_ir_write(irw), .o_reg_write(rw), .o_mem_write(mw),
    .o_adr_src(adr), .o_result_src(rs), .o_alu_src_a(sa), .o_alu_src_b(sb),
    .o_imm_src(imm), .o_alu_control(alu), .o_illegal_op(ill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    allow_stall = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t  e, a;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {pcw, irw, rw, mw, adr, rs, sa, sb, imm, alu, ill};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pcw%b irw%b rw%b mw%b adr%b rs%b sa%b sb%b imm%b alu%h ill%b, expected pcw%b irw%b rw%b mw%b adr%b rs%b sa%b sb%b imm%b alu%h ill%b",
                 t, a.pcw, a.irw, a.rw, a.mw, a.adr, a.rs, a.sa, a.sb, a.imm, a.alu, a.ill,
                 e.pcw, e.irw, e.rw, e.mw, e.adr, e.rs, e.sa, e.sb, e.imm, e.alu, e.ill);
      end
    end
  end

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] fn, input logic b, input bit is_r);
    case (fn)
      3'd0: return (is_r && b) ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return b ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic exp_t blank();
    exp_t e = '0;
    e.imm = imm_of(op);
    return e;
  endfunction

  task automatic scramble();
    zero = 1'($urandom);
    lsb  = 1'($urandom);
    mr   = 1'($urandom);
  endtask

  task automatic issue(input exp_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch();
    exp_t e;
    for (int n = 0; n < 16; n++) begin
      scramble();
      mr = (!allow_stall || n >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      e = blank();
      e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr;
      issue(e, "fetch");
      if (mr) break;
    end
  endtask

  task automatic do_aluwb();
    exp_t e;
    scramble();
    e = blank(); e.rw = 1'b1;
    issue(e, "aluwb");
  endtask

  // Memory wait phase: 'stalls' < 0 means random wait length. With rst_mid
  // a reset is applied in the first wait cycle and the instruction ends there.
  task automatic mem_wait(input bit is_store, input int stalls, input bit rst_mid,
                          output bit aborted);
    exp_t e;
    aborted = 1'b0;
    for (int n = 0; n < 16; n++) begin
      scramble();
      mr = (stalls >= 0) ? (n >= stalls) : (n >= 5 || $urandom_range(0, 2) == 0);
      e = blank(); e.adr = 1'b1;
      if (rst_mid) begin
        rst = 1'b1;
        issue(e, is_store ? "store_rst" : "load_rst");
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      e.mw = is_store;
      issue(e, is_store ? "memwrite" : "memread");
      if (mr) break;
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] fn, input logic b,
                           input int stalls, input bit rst_mid, input int br_flag);
    exp_t e;
    bit   aborted;
    bit   taken;
    op = o; f3 = fn; b5 = b;
    do_fetch();
    scramble();
    e = blank(); e.sa = 2'b01; e.sb = 2'b01;
    issue(e, "decode");
    case (o)
      7'b0000011, 7'b0100011: begin
        scramble();
        e = blank(); e.sa = 2'b10; e.sb = 2'b01;
        issue(e, "memadr");
        mem_wait(o == 7'b0100011, stalls, rst_mid, aborted);
        if (!aborted && o == 7'b0000011) begin
          scramble();
          e = blank(); e.rs = 2'b01; e.rw = 1'b1;
          issue(e, "memwb");
        end
      end
      7'b0110011, 7'b0010011: begin
        scramble();
        e = blank(); e.sa = 2'b10;
        e.sb  = (o == 7'b0010011) ? 2'b01 : 2'b00;
        e.alu = alu_of(fn, b, o == 7'b0110011);
        issue(e, "exec");
        do_aluwb();
      end
      7'b1100011: begin
        if (fn == 3'd2 || fn == 3'd3) begin
          run_illegal();
        end else begin
          scramble();
          if (br_flag >= 0) begin
            zero = 1'(br_flag);
            lsb  = 1'(br_flag);
          end
          case (fn)
            3'd0: taken = zero;
            3'd1: taken = !zero;
            3'd4, 3'd6: taken = lsb;
            default: taken = !lsb;
          endcase
          e = blank(); e.sa = 2'b10; e.pcw = taken;
          e.alu = (fn < 3'd2) ? 4'd1 : (fn < 3'd6) ? 4'd3 : 4'd4;
          issue(e, "branch");
        end
      end
      7'b1101111: begin
        scramble();
        e = blank(); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
        issue(e, "jal");
        do_aluwb();
      end
      7'b0110111: begin
        scramble();
        e = blank(); e.sa = 2'b11; e.sb = 2'b01;
        issue(e, "lui");
        do_aluwb();
      end
      default: run_illegal();
    endcase
  endtask

  task automatic run_illegal();
    exp_t e;
    for (int n = 0; n < 10; n++) begin
      scramble();
      e = blank(); e.ill = 1'b1;
      issue(e, "illegal_hold");
    end
    scramble();
    rst = 1'b1;
    e = blank();
    issue(e, "illegal_rst");
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] opc;
    int         pick;
    rst = 1'b1; op = 7'b0010011; f3 = 3'd0; b5 = 1'b0;
    zero = 1'b0; lsb = 1'b0; mr = 1'b0;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      scramble();
      e = blank(); e.sb = 2'b10; e.rs = 2'b10;
      issue(e, "reset_fetch");
    end
    rst = 1'b0;

    run_instr(7'b0110011, 3'd0, 1'b0, -1, 1'b0, -1);   // add
    run_instr(7'b0000011, 3'd2, 1'b0,  3, 1'b0, -1);   // lw, 3 stall cycles
    run_instr(7'b1100011, 3'd1, 1'b0, -1, 1'b0,  1);   // bne, Zero=1
    run_instr(7'b1100011, 3'd1, 1'b0, -1, 1'b0,  0);   // bne, Zero=0
    run_instr(7'b0010011, 3'd5, 1'b1, -1, 1'b0, -1);   // srai
    run_instr(7'b0010011, 3'd1, 1'b0, -1, 1'b0, -1);   // slli
    run_instr(7'b0110011, 3'd0, 1'b1, -1, 1'b0, -1);   // sub
    run_instr(7'b1111111, 3'd0, 1'b0, -1, 1'b0, -1);   // illegal opcode
    run_instr(7'b0100011, 3'd2, 1'b0,  2, 1'b1, -1);   // sw, reset mid-write
    run_instr(7'b0100011, 3'd2, 1'b0,  2, 1'b0, -1);   // sw, 2 stalls

    allow_stall = 1'b1;
    for (int i = 0; i < 80; i++) begin
      pick = $urandom_range(0, 15);
      case (pick)
        0, 1:   opc = 7'b0000011;
        2, 3:   opc = 7'b0100011;
        4, 5:   opc = 7'b0110011;
        6, 7:   opc = 7'b0010011;
        8, 9, 10: opc = 7'b1100011;
        11:     opc = 7'b1101111;
        12:     opc = 7'b0110111;
        13:     opc = 7'b0000000;
        default: opc = 7'($urandom);
      endcase
      run_instr(opc, 3'($urandom), 1'($urandom), -1,
                ($urandom_range(0, 7) == 0), -1);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_CTRL_WIDTH, default 4: SHALL set the width of ALUControl.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Op  input  7  SHALL be the instruction opcode, from the registered instruction.
REQ-005 Funct3  input  3  SHALL be the instruction funct3.
REQ-006 Funct7b5  input  1  SHALL be instruction bit 30.
REQ-007 Zero  input  1  SHALL be the ALU equality flag: 1 when SrcA equals SrcB.
REQ-008 ResultLsb  input  1  SHALL be ALUResult bit 0 (the slt/sltu outcome).
REQ-009 MemReady  input  1  SHALL indicate the memory completes the current access this cycle.
REQ-010 PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  SHALL be the write enables.
REQ-011 AdrSrc  output  1  SHALL select the memory address: 0 PC, 1 Result.
REQ-012 ResultSrc  output  2  SHALL select Result: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-013 ALUSrcA  output  2  SHALL select SrcA: 00 PC, 01 OldPC, 10 RD1, 11 zero.
REQ-014 ALUSrcB  output  2  SHALL select SrcB: 00 RD2, 01 ImmExt, 10 constant 4.
REQ-015 ImmSrc  output  3  SHALL select the immediate: 000 I, 001 S, 010 B, 011 J, 100 U; combinational from Op.
REQ-016 ALUControl  output  ALU_CTRL_WIDTH  SHALL be the ALU op: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.
REQ-017 IllegalOp  output  1  SHALL be high while in state ILLEGAL.

Function
REQ-018 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, ILLEGAL; outputs are Moore except where gated by MemReady or branch outcome.
REQ-019 Every output not listed for a state SHALL be 0; ALUControl defaults to 0000.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=MemReady; advance to DECODE only when MemReady=1, else hold.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target to ALUOut); next state by Op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other Op, or branch Funct3 010/011 -> ILLEGAL.
REQ-022 MEMADR: ALUSrcA=10, ALUSrcB=01, add; -> MEMREAD for loads, MEMWRITE for stores.
REQ-023 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then -> MEMWB.
REQ-024 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-025 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until the cycle MemReady=1; then -> FETCH.
REQ-026 EXECR: ALUSrcA=10, ALUSrcB=00, decoded op; -> ALUWB.
REQ-027 EXECI: ALUSrcA=10, ALUSrcB=01, decoded op; -> ALUWB.
REQ-028 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-029 Decoded op by Funct3:
  - 000: add, or sub when R-type and Funct7b5=1
  - 001 sll; 010 slt; 011 sltu; 100 xor
  - 101: srl, or sra when Funct7b5=1 (R and I)
  - 110 or; 111 and.
REQ-030 BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00; -> FETCH. Per Funct3:
  - 000/001: ALUControl=sub; PCWrite=Zero / ~Zero
  - 100/101: ALUControl=slt; PCWrite=ResultLsb / ~ResultLsb
  - 110/111: ALUControl=sltu; PCWrite=ResultLsb / ~ResultLsb.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; -> ALUWB (rd=OldPC+4).
REQ-032 LUI: ALUSrcA=11, ALUSrcB=01, add; -> ALUWB.
REQ-033 ILLEGAL: all write enables 0, IllegalOp=1; exit only by reset.

Reset
REQ-034 rst=1 at a rising edge SHALL force state FETCH regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-035 While rst=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0 and IllegalOp SHALL be 0.

Verification
REQ-036 add x3,x1,x2 (Op 0110011, f3 000, b5 0), MemReady=1 -> FETCH, DECODE, EXECR (ALUControl 0000), ALUWB (RegWrite=1), FETCH: 4 cycles.
REQ-037 lw with MemReady low 3 cycles in MEMREAD -> state holds 3 cycles, RegWrite only in MEMWB, 5+3 cycles total.
REQ-038 bne with Zero=1 -> ALUControl 0001, PCWrite=0; same with Zero=0 -> PCWrite=1 in BRANCH.
REQ-039 srai (Op 0010011, f3 101, b5 1) -> ALUControl 0111; slli -> 0010.
REQ-040 Op 1111111 -> ILLEGAL, IllegalOp=1 persists for 10 cycles; rst pulse -> FETCH, IllegalOp=0.
REQ-041 sw with rst asserted during MEMWRITE -> MemWrite=0 during reset, FETCH on the next cycle.
